// File: rtl/pwm_duty_decoder.sv
// Eight-channel PWM duty decoder: counts high samples per channel over a PERIOD-sample frame aligned to pwm[0].
// Optional glitch detection (sticky per-channel err) is compiled in by defining PWM_DEC_GLITCH_EN.
module pwm_duty_decoder #(
    parameter int unsigned PERIOD = 101,
    parameter int unsigned CH     = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [CH-1:0] pwm,
    input  logic          en,
    input  logic [2:0]    sel,
    input  logic          clr_err,
    output logic [6:0]    duty,
    output logic          valid,
    output logic          frame_done,
    output logic [CH-1:0] err
);

    localparam int unsigned CW = 7;
    localparam logic [CW-1:0] LAST = CW'(PERIOD - 1);

    typedef enum logic [1:0] {IDLE, ALIGN, RUN} state_t;

    state_t        r_state;
    state_t        w_next;
    logic [CH-1:0] r_prev;
    logic [CH-1:0] w_rise;
    logic [CW-1:0] r_phase;
    logic [CW-1:0] r_acc  [CH];
    logic [CW-1:0] r_duty [CH];
    logic          r_valid;
    logic          r_frame_done;
    logic          w_last;

    assign w_rise = pwm & ~r_prev;
    assign w_last = (r_phase == LAST);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_state <= IDLE;
        else        r_state <= w_next;
    end

    // Losing en always wins; ALIGN waits for the frame reference edge.
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (en) w_next = ALIGN;
            ALIGN:   if (!en) w_next = IDLE;
                     else if (w_rise[0]) w_next = RUN;
            RUN:     if (!en) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_prev       <= '0;
            r_phase      <= '0;
            r_valid      <= 1'b0;
            r_frame_done <= 1'b0;
            for (int k = 0; k < int'(CH); k++) begin
                r_acc[k]  <= '0;
                r_duty[k] <= '0;
            end
        end else begin
            r_prev       <= pwm;
            r_frame_done <= 1'b0;
            case (r_state)
                ALIGN: begin
                    if (en && w_rise[0]) begin
                        r_phase <= CW'(1);
                        for (int k = 0; k < int'(CH); k++) r_acc[k] <= CW'(pwm[k]);
                    end else begin
                        r_phase <= '0;
                        for (int k = 0; k < int'(CH); k++) r_acc[k] <= '0;
                    end
                end
                RUN: begin
                    if (!en) begin
                        r_phase <= '0;
                        for (int k = 0; k < int'(CH); k++) r_acc[k] <= '0;
                    end else if (w_last) begin
                        r_phase      <= '0;
                        r_valid      <= 1'b1;
                        r_frame_done <= 1'b1;
                        for (int k = 0; k < int'(CH); k++) begin
                            r_duty[k] <= r_acc[k] + CW'(pwm[k]);
                            r_acc[k]  <= '0;
                        end
                    end else begin
                        r_phase <= r_phase + CW'(1);
                        for (int k = 0; k < int'(CH); k++) r_acc[k] <= r_acc[k] + CW'(pwm[k]);
                    end
                end
                default: begin
                    r_phase <= '0;
                    for (int k = 0; k < int'(CH); k++) r_acc[k] <= '0;
                end
            endcase
        end
    end

    assign duty       = r_duty[sel];
    assign valid      = r_valid;
    assign frame_done = r_frame_done;

`ifdef PWM_DEC_GLITCH_EN
    logic [CH-1:0] r_err;
    logic [CH-1:0] w_glitch;

    // Any rising edge away from frame start is misaligned; a new set beats a same-cycle clear.
    assign w_glitch = (r_state == RUN && r_phase != '0) ? w_rise : '0;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_err <= '0;
        else        r_err <= (clr_err ? '0 : r_err) | w_glitch;
    end

    assign err = r_err;
`else
    logic [CH-1:0] w_unused;
    assign w_unused = {clr_err, w_rise[CH-1:1]};
    assign err      = '0;
`endif

endmodule

// File: doc/pwm_duty_decoder.md
PWM_DUTY_DECODER -- requirements
Module: pwm_duty_decoder

Interface
REQ-001 SHALL have parameter PERIOD, default 101: samples per PWM frame, legal range 2..127.
REQ-002 SHALL have parameter CH, default 8: PWM channel count, fixed at 8 for this revision.
REQ-003 SHALL have port clk, input, 1 bit: sole clock; all state updates on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port pwm, input, 8 bits: PWM lines, synchronous to clk; pwm[0] is the frame reference.
REQ-006 SHALL have port en, input, 1 bit: decoder enable.
REQ-007 SHALL have port sel, input, 3 bits: channel select for the duty readout.
REQ-008 SHALL have port clr_err, input, 1 bit: clears err.
REQ-009 SHALL have port duty, output, 7 bits: captured high-count of channel sel, combinational mux of registers.
REQ-010 SHALL have port valid, output, 1 bit: at least one frame captured since reset.
REQ-011 SHALL have port frame_done, output, 1 bit: one-cycle pulse after each capture.
REQ-012 SHALL have port err, output, 8 bits: sticky per-channel misaligned-edge flags.

Function
REQ-013 SHALL implement FSM states IDLE, ALIGN, RUN, plus an 8-bit prev register holding the last sampled pwm value.
REQ-014 SHALL define rise[k] as pwm[k]=1 with prev[k]=0.
REQ-015 In IDLE, SHALL hold phase and all accumulators at 0 and move to ALIGN when en=1.
REQ-016 In ALIGN, on rise[0], SHALL load each acc[k] with pwm[k], set phase to 1 and enter RUN; otherwise SHALL remain in ALIGN indefinitely.
REQ-017 In RUN with phase<PERIOD-1, SHALL add pwm[k] to acc[k] and increment phase.
REQ-018 In RUN with phase=PERIOD-1, SHALL load duty_reg[k] with acc[k]+pwm[k], clear acc and phase, and set valid.
REQ-019 In RUN with phase=PERIOD-1, SHALL assert frame_done for exactly the following cycle.
REQ-020 Captured values SHALL range 0..PERIOD; a constant-high channel reads PERIOD and a constant-low channel reads 0.
REQ-021 Accumulators SHALL be 7 bits and SHALL never wrap for legal PERIOD.
REQ-022 If en=0 in ALIGN or RUN, SHALL enter IDLE next cycle, discard the partial frame, emit no frame_done, and retain duty_reg and valid.
REQ-023 After re-enable, SHALL realign on the next rise[0]; no capture from before the disable is reused.
REQ-024 duty SHALL follow sel combinationally with zero latency.
REQ-025 prev SHALL update every cycle in every state.

Reset
REQ-026 reset=0 SHALL immediately force IDLE and clear phase, acc, duty_reg, prev, valid, frame_done and err, including mid-frame.
REQ-027 The first capture after reset release SHALL require a full ALIGN-then-RUN sequence.

Configuration
REQ-028 Macro PWM_DEC_GLITCH_EN SHALL compile glitch detection in or out.
REQ-029 With PWM_DEC_GLITCH_EN defined, in RUN a rise[k] at phase not equal to 0 SHALL set err[k].
REQ-030 With PWM_DEC_GLITCH_EN defined, clr_err=1 SHALL clear err; a set in the same cycle SHALL take priority over the clear.
REQ-031 With PWM_DEC_GLITCH_EN undefined, err SHALL be constant 0, clr_err SHALL be ignored, and no detection logic SHALL be present.

Verification
REQ-032 Reset, en=1, aligned frames of 101 with ch k high for 10*(k+1) cycles -> after the first frame, duty reads 10,20,...,80 for sel 0..7; valid=1; one frame_done per frame.
REQ-033 Ch0 duty 50, ch1 always high, ch2 always low -> duty reads 50, 101, 0.
REQ-034 reset asserted at phase 40 of the second frame -> duty=0, valid=0, err=0 immediately; no frame_done until one full aligned frame after release.
REQ-035 PWM_DEC_GLITCH_EN defined, extra pulse on pwm[3] at phase 50 -> err=8'h08 next cycle and duty[3] includes the extra cycles; clr_err pulse -> err=0. Macro undefined -> err stays 0.
REQ-036 en dropped at phase 60 -> no frame_done and duty unchanged; en restored -> first capture one full frame after the next pwm[0] rise.
REQ-037 en=1 with pwm[0] held low for 500 cycles -> FSM remains in ALIGN, no frame_done, valid stays 0.
